// File: rtl/sample_pack_fifo_if.sv
// Sample-in / byte-out handshake bundle for sample_pack_fifo.
// The master side drives samples and strobes; the slave side is the packer.
interface sample_pack_fifo_if #(
    parameter int SAMPLE_W   = 10,
    parameter int DEPTH_BITS = 10
);
    logic                  clr;
    logic                  pack_en;
    logic [SAMPLE_W-1:0]   wr_data;
    logic                  wr_en;
    logic                  wr_ready;
    logic                  flush;
    logic                  flush_done;
    logic                  rd_en;
    logic [7:0]            rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic                  full;
    logic [DEPTH_BITS:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, pack_en, wr_data, wr_en, flush, rd_en,
        input  wr_ready, flush_done, rd_data, rd_valid, empty, full, count,
               overflow, underflow
    );

    modport slave (
        input  clr, pack_en, wr_data, wr_en, flush, rd_en,
        output wr_ready, flush_done, rd_data, rd_valid, empty, full, count,
               overflow, underflow
    );
endinterface

// File: rtl/sample_pack_fifo.sv
// Packs SAMPLE_W-bit ADC samples MSB-first into a byte FIFO for the 8-bit readout.
//   state | meaning
//   RUN   | accept samples, drain whole bytes into the FIFO
//   FLUSH | no new samples; drain whole bytes, then push the zero-padded tail
//   DONE  | flush_done high for this one cycle, then back to RUN
module sample_pack_fifo #(
    parameter int SAMPLE_W   = 10,
    parameter int DEPTH_BITS = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    sample_pack_fifo_if.slave bus
);
    localparam int AW    = SAMPLE_W + 7;
    localparam int CW    = $clog2(SAMPLE_W + 8);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = {1'b1, {DEPTH_BITS{1'b0}}};

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t                state;
    logic [AW-1:0]         acc;
    logic [CW-1:0]         acc_cnt;
    logic                  pack_q;
    logic [7:0]            mem [0:DEPTH-1];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic [7:0]            rd_data_q;
    logic                  rd_valid_q;
    logic                  flush_done_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic          full, empty, wr_ready, pop, can_push, drain, pad, push, accept;
    logic          mode_pack;
    logic [AW-1:0] sample_al;
    logic [CW-1:0] sample_n;
    logic [7:0]    push_byte;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign wr_ready  = (state == RUN) && (acc_cnt < CW'(8));
    assign pop       = bus.rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a byte.
    assign can_push  = !full || pop;
    assign drain     = (state != DONE) && (acc_cnt >= CW'(8)) && can_push;
    assign pad       = (state == FLUSH) && (acc_cnt != '0) && (acc_cnt < CW'(8)) && can_push;
    assign push      = drain || pad;
    assign accept    = bus.wr_en && wr_ready;
    assign push_byte = acc[AW-1 -: 8];

    // Pack mode only changes on a byte boundary, i.e. with an empty accumulator.
    assign mode_pack = (acc_cnt == '0) ? bus.pack_en : pack_q;
    assign sample_al = mode_pack ? {bus.wr_data, 7'b0}
                                 : {bus.wr_data[SAMPLE_W-1 -: 8], {(SAMPLE_W-1){1'b0}}};
    assign sample_n  = mode_pack ? CW'(SAMPLE_W) : CW'(8);

    always_ff @(posedge clk) begin
        if (push && !bus.clr)
            mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            acc          <= '0;
            acc_cnt      <= '0;
            pack_q       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            flush_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else if (bus.clr) begin
            state        <= RUN;
            acc          <= '0;
            acc_cnt      <= '0;
            pack_q       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            flush_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            // Accumulator bits below acc_cnt are always zero, so OR appends and pad is free.
            if (accept) begin
                acc     <= acc | (sample_al >> acc_cnt);
                acc_cnt <= acc_cnt + sample_n;
                if (acc_cnt == '0)
                    pack_q <= bus.pack_en;
            end else if (drain) begin
                acc     <= acc << 8;
                acc_cnt <= acc_cnt - CW'(8);
            end else if (pad) begin
                acc     <= '0;
                acc_cnt <= '0;
            end

            if (push) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            case ({push, pop})
                2'b10:   count <= count + (DEPTH_BITS+1)'(1);
                2'b01:   count <= count - (DEPTH_BITS+1)'(1);
                default: count <= count;
            endcase

            rd_valid_q <= pop;
            if (pop)
                rd_data_q <= mem[rd_ptr];

            if (bus.wr_en && !wr_ready) overflow_q  <= 1'b1;
            if (bus.rd_en && empty)     underflow_q <= 1'b1;

            flush_done_q <= 1'b0;
            case (state)
                RUN:   if (bus.flush) state <= FLUSH;
                FLUSH: if (pad || acc_cnt == '0) begin
                           state        <= DONE;
                           flush_done_q <= 1'b1;
                       end
                DONE:  state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.wr_ready   = wr_ready;
    assign bus.flush_done = flush_done_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.count      = count;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
endmodule

// File: doc/sample_pack_fifo.md
Name: sample_pack_fifo

Overview:
- Single-clock packing buffer between the ADC sample capture path and the 8-bit readout interface.
- Accepts SAMPLE_W-bit samples and stores them as MSB-first, tightly bit-packed bytes in an internal byte FIFO.
- Generalises the fixed 10-bit variable-width RAM to any sample width from 8 to 16 bits, a parametrised depth, a truncate mode, and a flush/pad sequence with full/empty and error flags.

Parameters:
- SAMPLE_W, 10, sample width in bits; legal range 8..16.
- DEPTH_BITS, 10, log2 of byte FIFO depth; 1024 bytes at the default.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear: empties the FIFO and accumulator, clears sticky flags, returns the FSM to RUN.
- pack_en  input  1  1 = tight bit-packing; 0 = truncate each sample to its top 8 bits (one byte per sample). Sampled only when the accumulator is empty.
- wr_data  input  SAMPLE_W  sample in.
- wr_en  input  1  write strobe.
- wr_ready  output  1  a sample is accepted when wr_en && wr_ready.
- flush  input  1  single-cycle pulse: drain the accumulator and pad the final partial byte.
- flush_done  output  1  one-cycle pulse when the flush completes.
- rd_en  input  1  read strobe.
- rd_data  output  8  read byte.
- rd_valid  output  1  rd_data valid, one cycle after an accepted rd_en.
- empty  output  1  FIFO holds no bytes.
- full  output  1  FIFO holds 2^DEPTH_BITS bytes.
- count  output  DEPTH_BITS+1  number of bytes in the FIFO.
- overflow  output  1  sticky: set when wr_en is asserted while wr_ready=0; the sample is dropped.
- underflow  output  1  sticky: set when rd_en is asserted while empty=1; the read is ignored.

Behaviour:
- Reset (asynchronous, reset_n=0) and clr (synchronous, clr=1) produce the same state:
  - pointers, count and accumulator cleared; FSM in RUN.
  - outputs: wr_ready=1, flush_done=0, rd_data=0, rd_valid=0, empty=1, full=0, count=0, overflow=0, underflow=0.
- Accumulator:
  - acc register of SAMPLE_W+7 bits with bit count acc_cnt.
  - An accepted sample is appended below the existing bits; the first sample occupies the MSBs.
  - In truncate mode an accepted sample contributes only wr_data[SAMPLE_W-1:SAMPLE_W-8], i.e. 8 bits.
- Drain:
  - Each cycle, if acc_cnt>=8 and !full, the top 8 accumulator bits are pushed into the FIFO and acc_cnt decreases by 8.
  - At most one byte is pushed per cycle.
- wr_ready = (state==RUN) && (acc_cnt<8). Accept and drain are therefore never in the same cycle.
  - 10-bit packed throughput: 4 samples per 9 cycles worst case.
- FSM states and transitions:
  - RUN: normal operation. On flush go to FLUSH; wr_ready drops the next cycle.
  - FLUSH: drain whole bytes. When 0<acc_cnt<8 and !full, push {remaining bits, zero pad}, set acc_cnt=0 and go to DONE. If acc_cnt==0, go directly to DONE.
  - DONE: pulse flush_done for one cycle, then return to RUN.
  - flush while already in FLUSH or DONE is ignored.
- FIFO:
  - Circular buffer of 2^DEPTH_BITS bytes; pointers wrap modulo the depth.
  - full = count==2^DEPTH_BITS; empty = count==0.
  - A simultaneous push and pop leaves count unchanged. This is legal when full if a pop occurs that cycle; the pop frees the slot combinationally, so the push is allowed.
  - When full and not popping, the drain stalls, the accumulator holds its bits, and wr_ready falls once acc_cnt>=8. No data is lost except on an overflow drop.
- Read:
  - rd_en && !empty → rd_data is registered with the head byte and rd_valid=1 on the next cycle.
  - Otherwise rd_valid=0 and rd_data holds its last value.
- clr has priority over every other input. Reset mid-flush aborts the flush with no flush_done.

Test Plan:
- SAMPLE_W=10, pack_en=1, write 0x1AA, 0x1BC, 0x2DA, 0x200 → count=5; reads return 0x6A, 0x9B, 0xCB, 0x6A, 0x00, each with rd_valid one cycle after rd_en.
- Write 0x3FF, then pulse flush → bytes 0xFF, 0xC0; flush_done pulses exactly once; wr_ready stays 0 from the cycle after flush until after the flush_done cycle.
- pack_en=0, write 0x1AA, 0x3FF, 0x001 → reads return 0x6A, 0xFF, 0x00.
- DEPTH_BITS=4, pack_en=0, write 17 samples with no reads → full=1 and count=16; wr_ready falls after the accumulator fills; asserting wr_en then sets overflow; reading one byte resumes the drain and the 17th byte arrives intact.
- rd_en on an empty FIFO → underflow=1, rd_valid=0; clr → underflow=0, empty=1; 20 write/read cycles wrapping a 16-deep FIFO → data read out in order.
- Assert reset_n=0 in the middle of a FLUSH → all outputs take their reset values immediately (asynchronously); no flush_done pulse follows.
